opamp_share_arb: RTL and testbench
==================================

# opamp_share_arb

Round-robin arbiter and sequencer that shares one OpAmpSEO-style differential amplifier stage among several requesters. Each requester presents a differential input pair; the block grants the amplifier and drives its input_Plus/input_Minus tri-state nets. It then waits a fixed settle time, samples output_Neutral, returns the result to the winner and releases the nets to high-Z. It sits between digital control logic and the DifferentialQBit analog-model fabric.

## Interface

- NREQ, 4: number of requesters, 2..16
- SETTLE_CYC, 3: cycles the inputs are held before sampling, >=1
- RELEASE_CYC, 1: high-Z guard cycles after each transaction, >=1
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  level request per requester
- req_plus  input  NREQ  per-requester value for input_Plus
- req_minus  input  NREQ  per-requester value for input_Minus
- gnt  output  NREQ  one-hot grant; at most one bit set
- done  output  NREQ  one-cycle pulse to the winner when result is valid
- result  output  1  sampled output_Neutral; held until the next sample
- unstable  output  1  double-sample mismatch flag (see Configuration)
- busy  output  1  state != IDLE
- amp_oe  output  1  tri-state enable for the amplifier input nets
- amp_in_plus  output  1  driven onto input_Plus when amp_oe=1
- amp_in_minus  output  1  driven onto input_Minus when amp_oe=1
- amp_out  input  1  output_Neutral of the shared amplifier

## Operation

- Reset values: gnt=0, done=0, result=0, unstable=0, busy=0, amp_oe=0, amp_in_plus=0, amp_in_minus=0. state=IDLE, last winner=NREQ-1, so requester 0 has first priority.
- Asynchronous reset mid-transaction aborts immediately. amp_oe drops with rst; no done pulse is issued.
- IDLE: if any req bit is set, pick the first set bit after the last winner, searching upward and wrapping NREQ-1->0. Latch the winner index and its req_plus/req_minus, then go to DRIVE.
- DRIVE (1 cycle): amp_oe=1, amp_in_* = latched values, gnt[winner]=1. Load the settle counter with SETTLE_CYC-1. Go to SETTLE.
- SETTLE: decrement the counter; at 0 go to SAMPLE. Counter width is $clog2(SETTLE_CYC).
- SAMPLE: result<=amp_out; done[winner]=1 for this cycle only; update the last winner. Go to RELEASE.
- RELEASE: amp_oe=0, gnt=0 for RELEASE_CYC cycles, then IDLE.
- gnt stays high from DRIVE through SAMPLE. amp_oe and amp_in_* are stable for that whole window.
- Latched inputs are used throughout; changes to req_plus/req_minus after arbitration are ignored.
- Dropping req mid-transaction does not cancel the transaction; done still pulses.
- req still high in the IDLE cycle after RELEASE counts as a new request, subject to round-robin against the other requesters.
- A req arriving while busy waits; nothing is queued beyond the req level itself.

## Timing

- req sampled high at edge k in IDLE → DRIVE in cycle k+1, SETTLE in k+2..k+1+SETTLE_CYC, SAMPLE and done in cycle k+2+SETTLE_CYC.
- Back-to-back transaction period: 2+SETTLE_CYC+RELEASE_CYC+1 cycles, counting the IDLE arbitration cycle.
- All outputs are registered; no combinational path from req to gnt or amp_oe.

## Configuration

- OPAMP_ARB_DOUBLE_SAMPLE_EN defined: SAMPLE takes two consecutive cycles (SAMPLE_A, SAMPLE_B).
  - result = the SAMPLE_B value.
  - unstable<=(A!=B), updated in the same cycle as done.
  - done pulses in SAMPLE_B, so latency grows by 1 cycle.
- Not defined: single SAMPLE cycle; unstable is constant 0.

## Structure

- Shared package opamp_arb_pkg holds the state encoding localparams (IDLE, DRIVE, SETTLE, SAMPLE[_A/_B], RELEASE) and a shared max-NREQ constant. It is included next to DigitSupply.vh.
- Sub-module rr_pick: combinational round-robin picker with inputs req and last index, outputs a one-hot winner and its index.

## Test plan

- Reset mid-SETTLE (rst pulsed during cycle k+3) → amp_oe=0 and gnt=0 in the same cycle, no done; after release, req[2]=1 wins from IDLE.
- Single request with NREQ=4, SETTLE_CYC=3: req=0001, req_plus=1, req_minus=0, amp_out=1 → amp_oe high for cycles k+1..k+5, done=0001 at k+5, result=1, amp_in_plus=1.
- Round-robin fairness: req=1111 held → grant order 0,1,2,3,0 with no gaps beyond the period of 7 cycles.
- Input change after arbitration: req_plus flipped during SETTLE → amp_in_plus unchanged; req[1] dropped during SETTLE → done[1] still pulses.
- With OPAMP_ARB_DOUBLE_SAMPLE_EN: amp_out 1 then 0 across SAMPLE_A/B → result=0, unstable=1, done one cycle later than the base build; stable amp_out → unstable=0.

Source files
------------

// File: rtl/opamp_share_arb_pkg.sv
// opamp_arb_pkg: shared state encoding and sizing helpers for opamp_share_arb.
// Optional double-sample build: define OPAMP_ARB_DOUBLE_SAMPLE_EN.
package opamp_arb_pkg;

    localparam int MAX_NREQ = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_SAMPLE_B,
        ST_RELEASE
    } state_t;

    // Counter/index width that never collapses to zero bits.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/opamp_share_arb_if.sv
// opamp_share_arb_if: requester bus plus shared amplifier pins.
// master = control/analog side, slave = arbiter.
interface opamp_share_arb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] req_plus;
    logic [NREQ-1:0] req_minus;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] done;
    logic            result;
    logic            unstable;
    logic            busy;
    logic            amp_oe;
    logic            amp_in_plus;
    logic            amp_in_minus;
    logic            amp_out;

    modport master (
        output req, req_plus, req_minus, amp_out,
        input  gnt, done, result, unstable, busy,
        input  amp_oe, amp_in_plus, amp_in_minus
    );

    modport slave (
        input  req, req_plus, req_minus, amp_out,
        output gnt, done, result, unstable, busy,
        output amp_oe, amp_in_plus, amp_in_minus
    );
endinterface

// File: rtl/opamp_share_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Searches upward from last+1, wrapping NREQ-1 -> 0.
module rr_pick
    import opamp_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = cw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int            j;
    logic [IW-1:0] jj;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        j   = 0;
        jj  = '0;
        for (int i = NREQ; i >= 1; i--) begin
            j = int'(last) + i;
            if (j >= NREQ) j = j - NREQ;
            jj = IW'(j);
            if (req[jj]) begin
                idx = jj;
                any = 1'b1;
            end
        end
        onehot = any ? ({{(NREQ-1){1'b0}}, 1'b1} << idx) : '0;
    end

endmodule

// File: rtl/opamp_share_arb.sv
// opamp_share_arb: round-robin owner/sequencer for one shared amplifier.
// Define OPAMP_ARB_DOUBLE_SAMPLE_EN for the two-cycle sample with mismatch flag.
module opamp_share_arb
    import opamp_arb_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int SETTLE_CYC  = 3,
    parameter int RELEASE_CYC = 1
) (
    input logic              clk,
    input logic              rst,
    opamp_share_arb_if.slave bus
);

    localparam int IW = cw(NREQ);
    localparam int SW = cw(SETTLE_CYC);
    localparam int RW = cw(RELEASE_CYC);

`ifdef OPAMP_ARB_DOUBLE_SAMPLE_EN
    localparam state_t ST_LAST = ST_SAMPLE_B;
`else
    localparam state_t ST_LAST = ST_SAMPLE;
`endif

    state_t          state;
    state_t          next_state;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   last_idx;
    logic [IW-1:0]   pick_idx;
    logic [NREQ-1:0] pick_oh;
    logic            pick_any;
    logic [NREQ-1:0] sel_oh;
    logic            lat_plus;
    logic            lat_minus;
    logic            sel_plus;
    logic            sel_minus;
    logic [SW-1:0]   scnt;
    logic [RW-1:0]   rcnt;
    logic            oe_next;
`ifdef OPAMP_ARB_DOUBLE_SAMPLE_EN
    logic            sample_a;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (bus.req),
        .last   (last_idx),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next state plus the values the registered outputs will take.
    always_comb begin
        next_state = state;
        sel_oh     = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
        sel_plus   = lat_plus;
        sel_minus  = lat_minus;
        if (state == ST_IDLE) begin
            sel_oh    = pick_oh;
            sel_plus  = bus.req_plus[pick_idx];
            sel_minus = bus.req_minus[pick_idx];
        end
        unique case (state)
            ST_IDLE:     if (pick_any) next_state = ST_DRIVE;
            ST_DRIVE:    next_state = ST_SETTLE;
            ST_SETTLE:   if (scnt == '0) next_state = ST_SAMPLE;
            ST_SAMPLE:   next_state = (ST_LAST == ST_SAMPLE) ? ST_RELEASE
                                                             : ST_SAMPLE_B;
            ST_SAMPLE_B: next_state = ST_RELEASE;
            ST_RELEASE:  if (rcnt == '0) next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
        oe_next = next_state inside {ST_DRIVE, ST_SETTLE, ST_SAMPLE, ST_SAMPLE_B};
    end

    // Winner latch, settle/release counters and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_idx   <= '0;
            last_idx  <= IW'(NREQ - 1);
            lat_plus  <= 1'b0;
            lat_minus <= 1'b0;
            scnt      <= '0;
            rcnt      <= '0;
        end else begin
            if (state == ST_IDLE && pick_any) begin
                win_idx   <= pick_idx;
                lat_plus  <= sel_plus;
                lat_minus <= sel_minus;
            end
            if (state == ST_DRIVE) scnt <= SW'(SETTLE_CYC - 1);
            else if (state == ST_SETTLE && scnt != '0) scnt <= scnt - 1'b1;
            if (state == ST_LAST) begin
                last_idx <= win_idx;
                rcnt     <= RW'(RELEASE_CYC - 1);
            end else if (state == ST_RELEASE && rcnt != '0) begin
                rcnt <= rcnt - 1'b1;
            end
        end
    end

    // Registered outputs, computed from the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.gnt          <= '0;
            bus.done         <= '0;
            bus.result       <= 1'b0;
            bus.unstable     <= 1'b0;
            bus.busy         <= 1'b0;
            bus.amp_oe       <= 1'b0;
            bus.amp_in_plus  <= 1'b0;
            bus.amp_in_minus <= 1'b0;
`ifdef OPAMP_ARB_DOUBLE_SAMPLE_EN
            sample_a         <= 1'b0;
`endif
        end else begin
            bus.busy         <= next_state != ST_IDLE;
            bus.amp_oe       <= oe_next;
            bus.amp_in_plus  <= oe_next & sel_plus;
            bus.amp_in_minus <= oe_next & sel_minus;
            bus.gnt          <= oe_next ? sel_oh : '0;
            bus.done         <= (next_state == ST_LAST) ? sel_oh : '0;
            if (next_state == ST_LAST) bus.result <= bus.amp_out;
`ifdef OPAMP_ARB_DOUBLE_SAMPLE_EN
            if (next_state == ST_SAMPLE) sample_a <= bus.amp_out;
            if (next_state == ST_SAMPLE_B) bus.unstable <= sample_a != bus.amp_out;
`else
            bus.unstable     <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_opamp_share_arb.sv
// Bench for opamp_share_arb: transaction-level model plus directed vectors.
// Honours OPAMP_ARB_DOUBLE_SAMPLE_EN for the longer sample window.
module tb_opamp_share_arb;

    localparam int NREQ   = 4;
    localparam int SETTLE = 3;
    localparam int REL    = 1;
`ifdef OPAMP_ARB_DOUBLE_SAMPLE_EN
    localparam int LAT = 6;
    localparam bit DS  = 1'b1;
`else
    localparam int LAT = 5;
    localparam bit DS  = 1'b0;
`endif
    localparam int PERIOD = LAT + REL + 1;

    logic clk = 1'b0;
    logic rst;
    bit   chk_en = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    opamp_share_arb_if #(.NREQ(NREQ)) bus ();

    opamp_share_arb #(
        .NREQ        (NREQ),
        .SETTLE_CYC  (SETTLE),
        .RELEASE_CYC (REL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a transaction is (winner, latched inputs, cycle offset d).
    bit m_act, m_plus, m_minus, m_res, m_unst, m_a;
    int m_d, m_w, m_last, j;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 0; m_d = 0; m_w = 0; m_last = NREQ - 1;
            m_plus = 0; m_minus = 0; m_res = 0; m_unst = 0; m_a = 0;
        end else if (m_act) begin
            m_d++;
            if (DS && m_d == LAT - 1) m_a = bus.amp_out;
            if (m_d == LAT) begin
                m_res = bus.amp_out;
                if (DS) m_unst = (m_a != bus.amp_out);
                m_last = m_w;
            end
            if (m_d == LAT + REL + 1) m_act = 0;
        end else if (bus.req != '0) begin
            for (int i = 1; i <= NREQ; i++) begin
                j = (m_last + i) % NREQ;
                if (bus.req[j]) begin
                    m_w = j;
                    break;
                end
            end
            m_act   = 1;
            m_d     = 1;
            m_plus  = bus.req_plus[m_w];
            m_minus = bus.req_minus[m_w];
        end
    end

    bit              e_oe;
    logic [NREQ-1:0] e_oh;

    // Compare every cycle against the model.
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            e_oe = m_act && m_d <= LAT;
            e_oh = 4'(1 << m_w);
            check("busy", bus.busy, m_act);
            check("amp_oe", bus.amp_oe, e_oe);
            check("gnt", bus.gnt, e_oe ? e_oh : '0);
            check("done", bus.done, (m_act && m_d == LAT) ? e_oh : '0);
            check("amp_in_plus", bus.amp_in_plus, e_oe & m_plus);
            check("amp_in_minus", bus.amp_in_minus, e_oe & m_minus);
            check("result", bus.result, m_res);
            check("unstable", bus.unstable, m_unst);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req = '0;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic oh_to_idx(input logic [NREQ-1:0] oh, output int idx);
        idx = -1;
        for (int b = 0; b < NREQ; b++) if (oh[b]) idx = b;
    endtask

    int              seen_idx[$];
    int              seen_cyc[$];
    int              tmp;
    logic [NREQ-1:0] done_seen;

    initial begin
        rst = 1'b1;
        bus.req = '0; bus.req_plus = '0; bus.req_minus = '0; bus.amp_out = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_gnt", bus.gnt, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_oe", bus.amp_oe, 0);
        check("rst_result", bus.result, 0);
        check("rst_unstable", bus.unstable, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Single request from requester 0.
        @(negedge clk);
        bus.req = 4'b0001; bus.req_plus = 4'b0001; bus.req_minus = '0;
        bus.amp_out = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= PERIOD; c++) begin
            @(negedge clk);
            check("t1_oe", bus.amp_oe, c <= LAT);
            check("t1_plus", bus.amp_in_plus, c <= LAT);
            check("t1_done", bus.done, (c == LAT) ? 4'b0001 : 4'b0000);
            if (c == LAT) check("t1_result", bus.result, 1);
            if (c == 1) bus.req = '0;
        end

        // Fairness with all requesters held.
        do_reset();
        @(negedge clk);
        bus.req = 4'b1111; bus.req_plus = 4'b1010; bus.req_minus = 4'b0101;
        bus.amp_out = 1'b0;
        for (int c = 1; c <= 5 * PERIOD + 2; c++) begin
            @(negedge clk);
            if (bus.done != '0) begin
                oh_to_idx(bus.done, tmp);
                seen_idx.push_back(tmp);
                seen_cyc.push_back(c);
            end
        end
        bus.req = '0;
        check("rr_count", seen_idx.size() >= 5, 1);
        if (seen_idx.size() >= 5) begin
            check("rr_0", seen_idx[0], 0);
            check("rr_1", seen_idx[1], 1);
            check("rr_2", seen_idx[2], 2);
            check("rr_3", seen_idx[3], 3);
            check("rr_4", seen_idx[4], 0);
            check("rr_first", seen_cyc[0], LAT);
            for (int k = 1; k < 5; k++)
                check("rr_gap", seen_cyc[k] - seen_cyc[k-1], PERIOD);
        end
        repeat (2 * PERIOD) @(negedge clk);

        // Reset in the middle of SETTLE, then requester 2 alone.
        do_reset();
        @(negedge clk);
        bus.req = 4'b0001; bus.req_plus = 4'b0001;
        @(posedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_oe", bus.amp_oe, 0);
        check("mid_rst_gnt", bus.gnt, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_busy", bus.busy, 0);
        bus.req = 4'b0100; bus.req_plus = 4'b0100;
        @(negedge clk);
        rst = 1'b0;
        done_seen = '0;
        for (int c = 1; c <= PERIOD + 2; c++) begin
            @(negedge clk);
            if (bus.done != '0 && done_seen == '0) begin
                done_seen = bus.done;
                bus.req = '0;
            end
        end
        bus.req = '0;
        check("rst_win", done_seen, 4'b0100);
        repeat (PERIOD) @(negedge clk);

        // Inputs change after arbitration; req dropped mid-settle.
        do_reset();
        @(negedge clk);
        bus.req = 4'b0010; bus.req_plus = 4'b0010; bus.req_minus = '0;
        bus.amp_out = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= PERIOD; c++) begin
            @(negedge clk);
            check("chg_plus", bus.amp_in_plus, c <= LAT);
            check("chg_minus", bus.amp_in_minus, 0);
            check("chg_done", bus.done, (c == LAT) ? 4'b0010 : 4'b0000);
            if (c == 3) begin
                bus.req = '0; bus.req_plus = '0; bus.req_minus = 4'b1111;
            end
        end

        // amp_out changes across the sample window.
        do_reset();
        @(negedge clk);
        bus.req = 4'b0001; bus.req_plus = '0; bus.amp_out = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= PERIOD; c++) begin
            @(negedge clk);
            if (c == LAT) begin
                check("tog_result", bus.result, 0);
                check("tog_unstable", bus.unstable, DS);
                check("tog_done", bus.done, 4'b0001);
            end
            if (c == 1) bus.req = '0;
            bus.amp_out = (c < LAT - 1);
        end

        // Stable amp_out.
        @(negedge clk);
        bus.req = 4'b0100; bus.amp_out = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= PERIOD; c++) begin
            @(negedge clk);
            if (c == LAT) begin
                check("stab_result", bus.result, 1);
                check("stab_unstable", bus.unstable, 0);
                check("stab_done", bus.done, 4'b0100);
            end
            if (c == 1) bus.req = '0;
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
